bet_entry_ctrl: RTL and testbench

Player-side bet entry front end for the Indian-poker game core. It conditions the raw Up/Down/set buttons and keeps a clamped bet counter. On confirmation it offers the bet to the game core over a valid/ready handshake. It sits between the board buttons and the core's bet input and produces the same Up/Down/set intent the core consumes, as a single committed value.

---
 rtl/bet_entry_ctrl_pkg.sv | 18 +
 rtl/bet_entry_ctrl_btn_conditioner.sv | 45 ++++
 rtl/bet_entry_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bet_entry_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bet_entry_ctrl_pkg.sv
// Shared types and sizing helpers for the bet entry front end.
package bet_entry_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    OFFER = 2'd2
  } bet_state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_DEB_CYCLES = 4;

  // Width of a counter that holds 0..n-1; the debounce counter uses cnt_w(DEB_CYCLES).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bet_entry_ctrl_btn_conditioner.sv
// One raw button: input flop, debounce counter, registered rising-edge pulse.
// Pulse appears DEB_CYCLES+1 cycles after the raw level settles.
module btn_conditioner
  import bet_entry_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CW = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          raw_q;
  logic [CW-1:0] cnt;

  // cnt tracks consecutive samples that disagree with the accepted level
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      raw_q <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      raw_q <= raw;
      pulse <= 1'b0;
      if (raw_q != level) begin
        if (cnt == CNT_LAST) begin
          level <= raw_q;
          pulse <= raw_q;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/bet_entry_ctrl.sv
// Bet entry front end: conditioned Up/Down/set, clamped bet counter, valid/ready offer.
// Optional auto-repeat of held Up/Down is built when AUTO_REPEAT_EN is defined.
//   state | meaning
//   IDLE  | no request; cur_bet cleared
//   ENTER | player adjusting cur_bet within [min_bet, chips]
//   OFFER | bet_value/bet_fold held with bet_valid until bet_ready
module bet_entry_ctrl
  import bet_entry_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             Up,
  input  logic             Down,
  input  logic             set,
  input  logic             bet_req,
  input  logic [WIDTH-1:0] chips,
  input  logic [WIDTH-1:0] min_bet,
  output logic             bet_valid,
  input  logic             bet_ready,
  output logic [WIDTH-1:0] bet_value,
  output logic             bet_fold,
  output logic [WIDTH-1:0] cur_bet,
  output logic             busy
);

  if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("bet_entry_ctrl: DEB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  bet_state_t       state, state_nx;
  logic [WIDTH-1:0] cur_nx, val_nx, stepped;
  logic             valid_nx, fold_nx;
  logic             up_p, dn_p, set_p;
  logic             up_lvl, dn_lvl, set_lvl;
  logic             up_s, dn_s, inc, dec;
  logic             unused_lvl;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_up (
    .clk_sys(CLK), .rst_b(CLR), .raw(Up), .level(up_lvl), .pulse(up_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_dn (
    .clk_sys(CLK), .rst_b(CLR), .raw(Down), .level(dn_lvl), .pulse(dn_p)
  );
  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_btn_set (
    .clk_sys(CLK), .rst_b(CLR), .raw(set), .level(set_lvl), .pulse(set_p)
  );

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = cnt_w(RPT_MAX);

  logic [RW-1:0] rpt_cnt;
  logic          hold_up, hold_dn, rpt_fire;

  assign hold_up  = up_lvl & ~dn_lvl;
  assign hold_dn  = dn_lvl & ~up_lvl;
  assign rpt_fire = (state == ENTER) && (hold_up || hold_dn) && !up_p && !dn_p
                    && (rpt_cnt == '0);

  // Reloaded with the initial delay on every edge pulse and whenever the hold is broken
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rpt_cnt <= RW'(REPEAT_DELAY - 1);
    end else if (state != ENTER || !(hold_up || hold_dn) || up_p || dn_p) begin
      rpt_cnt <= RW'(REPEAT_DELAY - 1);
    end else if (rpt_cnt == '0) begin
      rpt_cnt <= RW'(REPEAT_PERIOD - 1);
    end else begin
      rpt_cnt <= rpt_cnt - 1'b1;
    end
  end

  assign up_s       = up_p | (rpt_fire & hold_up);
  assign dn_s       = dn_p | (rpt_fire & hold_dn);
  assign unused_lvl = set_lvl;
`else
  assign up_s       = up_p;
  assign dn_s       = dn_p;
  assign unused_lvl = ^{up_lvl, dn_lvl, set_lvl};
`endif

  assign inc = up_s & ~dn_s;
  assign dec = dn_s & ~up_s;

  always_comb begin
    state_nx = state;
    cur_nx   = cur_bet;
    val_nx   = bet_value;
    fold_nx  = bet_fold;
    valid_nx = bet_valid;
    stepped  = cur_bet;
    case (state)
      IDLE: begin
        if (bet_req) begin
          if (chips < min_bet) begin
            state_nx = OFFER;
            val_nx   = chips;
            fold_nx  = 1'b1;
            valid_nx = 1'b1;
          end else begin
            state_nx = ENTER;
            cur_nx   = min_bet;
          end
        end
      end
      ENTER: begin
        if (!bet_req) begin
          state_nx = IDLE;
          cur_nx   = '0;
        end else if (set_p) begin
          state_nx = OFFER;
          val_nx   = cur_bet;
          fold_nx  = 1'b0;
          valid_nx = 1'b1;
        end else begin
          if (inc && cur_bet < chips) stepped = cur_bet + WIDTH'(1);
          if (dec && cur_bet > min_bet) stepped = cur_bet - WIDTH'(1);
          // a shrinking chip count always wins over the player's choice
          if (chips < stepped) stepped = chips;
          cur_nx = stepped;
        end
      end
      OFFER: begin
        if (bet_ready) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          cur_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
        cur_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= IDLE;
      cur_bet   <= '0;
      bet_value <= '0;
      bet_fold  <= 1'b0;
      bet_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_bet   <= cur_nx;
      bet_value <= val_nx;
      bet_fold  <= fold_nx;
      bet_valid <= valid_nx;
      busy      <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_bet_entry_ctrl.sv
// Self-checking bench for bet_entry_ctrl: directed scenarios plus randomized betting rounds.
// Auto-repeat expectations follow AUTO_REPEAT_EN when the bench is built with it.
module tb_bet_entry_ctrl;
  localparam int W   = 8;
  localparam int D   = 4;
  localparam int RD  = 16;
  localparam int RP  = 4;

  logic         CLK = 1'b0;
  logic         CLR, Up, Down, set, bet_req, bet_ready;
  logic [W-1:0] chips, min_bet;
  logic         bet_valid, bet_fold, busy;
  logic [W-1:0] bet_value, cur_bet;

  int checks   = 0;
  int failures = 0;
  int m_bet;

  bet_entry_ctrl #(.WIDTH(W), .DEB_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .CLK(CLK), .CLR(CLR), .Up(Up), .Down(Down), .set(set), .bet_req(bet_req),
    .chips(chips), .min_bet(min_bet), .bet_valid(bet_valid), .bet_ready(bet_ready),
    .bet_value(bet_value), .bet_fold(bet_fold), .cur_bet(cur_bet), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // hold the given buttons for n cycles, then release and let the debouncers settle
  task automatic hold_btn(input logic u, input logic d, input logic s, input int n);
    Up = u; Down = d; set = s;
    tick(n);
    Up = 1'b0; Down = 1'b0; set = 1'b0;
    tick(D + 4);
  endtask

  // reference model: one accepted step in ENTER
  task automatic model_step(input int up, input int dn);
    if (up && !dn && m_bet < int'(chips)) m_bet++;
    if (dn && !up && m_bet > int'(min_bet)) m_bet--;
    if (m_bet > int'(chips)) m_bet = int'(chips);
  endtask

  task automatic enter_round(input int c, input int mb);
    chips = W'(c); min_bet = W'(mb);
    bet_req = 1'b1;
    tick(1);
    m_bet = mb;
  endtask

  task automatic confirm_and_check(input string tag);
    int n;
    set = 1'b1;
    n = 0;
    while (!bet_valid && n < 20) begin
      tick(1);
      n++;
    end
    chk_eq({tag, "_valid"}, bet_valid, 1);
    chk_eq({tag, "_value"}, bet_value, m_bet);
    chk_eq({tag, "_fold"}, bet_fold, 0);
    set = 1'b0;
    tick(D + 4);
  endtask

  task automatic handshake(input string tag);
    bet_ready = 1'b1;
    bet_req   = 1'b0;
    tick(1);
    bet_ready = 1'b0;
    chk_eq({tag, "_hs_valid"}, bet_valid, 0);
    chk_eq({tag, "_hs_cur"}, cur_bet, 0);
    chk_eq({tag, "_hs_busy"}, busy, 0);
    tick(2);
  endtask

  initial begin
    int exp_rpt, sel, c, mb;
    CLR = 1'b0; Up = 1'b0; Down = 1'b0; set = 1'b0;
    bet_req = 1'b0; bet_ready = 1'b0; chips = '0; min_bet = '0;
    tick(10);
    chk_eq("rst_valid", bet_valid, 0);
    chk_eq("rst_cur", cur_bet, 0);
    chk_eq("rst_value", bet_value, 0);
    chk_eq("rst_fold", bet_fold, 0);
    chk_eq("rst_busy", busy, 0);
    CLR = 1'b1;
    tick(2);

    // buttons in IDLE do nothing
    hold_btn(1, 0, 0, 2);
    chk_eq("idle_glitch", cur_bet, 0);
    hold_btn(1, 0, 0, 6);
    chk_eq("idle_hold_cur", cur_bet, 0);
    chk_eq("idle_hold_busy", busy, 0);

    // basic bet
    enter_round(20, 5);
    chk_eq("basic_enter", cur_bet, 5);
    chk_eq("basic_busy", busy, 1);
    repeat (3) begin hold_btn(1, 0, 0, D + 2); model_step(1, 0); end
    chk_eq("basic_up3", cur_bet, 8);
    hold_btn(0, 1, 0, D + 2); model_step(0, 1);
    chk_eq("basic_dn", cur_bet, 7);
    confirm_and_check("basic");
    tick(5);
    chk_eq("basic_stable_valid", bet_valid, 1);
    chk_eq("basic_stable_value", bet_value, 7);
    handshake("basic");

    // saturation
    enter_round(6, 5);
    repeat (4) begin hold_btn(1, 0, 0, D + 2); model_step(1, 0); end
    chk_eq("sat_hi", cur_bet, 6);
    repeat (3) begin hold_btn(0, 1, 0, D + 2); model_step(0, 1); end
    chk_eq("sat_lo", cur_bet, 5);
    bet_req = 1'b0;
    tick(2);

    // fold
    chips = 3; min_bet = 5; bet_req = 1'b1;
    tick(1);
    chk_eq("fold_valid", bet_valid, 1);
    chk_eq("fold_value", bet_value, 3);
    chk_eq("fold_flag", bet_fold, 1);
    handshake("fold");

    // abort from ENTER
    enter_round(20, 5);
    hold_btn(1, 0, 0, D + 2);
    chk_eq("abort_up", cur_bet, 6);
    bet_req = 1'b0;
    tick(1);
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_cur", cur_bet, 0);
    chk_eq("abort_valid", bet_valid, 0);
    tick(2);

    // simultaneous Up+Down, then async reset while offering
    enter_round(20, 5);
    hold_btn(1, 0, 0, D + 2); model_step(1, 0);
    hold_btn(1, 1, 0, D + 2);
    chk_eq("both_nochange", cur_bet, m_bet);
    confirm_and_check("prerst");
    CLR = 1'b0;
    #1;
    chk_eq("async_rst_valid", bet_valid, 0);
    chk_eq("async_rst_busy", busy, 0);
    bet_req = 1'b0;
    tick(3);
    CLR = 1'b1;
    tick(2);

    // long hold of Up
    enter_round(100, 1);
    Up = 1'b1;
    tick(60);
    Up = 1'b0;
    tick(D + 6);
    exp_rpt = 2;
`ifdef AUTO_REPEAT_EN
    for (int t = RD; t < 60; t += RP) exp_rpt++;
`endif
    chk_eq("long_hold", cur_bet, exp_rpt);
    bet_req = 1'b0;
    tick(2);

    // randomized rounds
    for (int r = 0; r < 25; r++) begin
      c  = $urandom_range(0, 60);
      mb = $urandom_range(0, 40);
      enter_round(c, mb);
      if (c < mb) begin
        chk_eq("rnd_fold_valid", bet_valid, 1);
        chk_eq("rnd_fold_value", bet_value, c);
        chk_eq("rnd_fold_flag", bet_fold, 1);
      end else begin
        chk_eq("rnd_enter", cur_bet, mb);
        for (int a = 0; a < 6; a++) begin
          sel = $urandom_range(0, 5);
          case (sel)
            0, 5: begin hold_btn(1, 0, 0, D + 2); model_step(1, 0); end
            1: begin hold_btn(0, 1, 0, D + 2); model_step(0, 1); end
            2: hold_btn(1, 1, 0, D + 2);
            3: begin
              if ($urandom_range(0, 1) == 1) hold_btn(1, 0, 0, $urandom_range(1, D - 1));
              else hold_btn(0, 1, 0, $urandom_range(1, D - 1));
            end
            default: begin
              chips = W'($urandom_range(0, 60));
              tick(2);
              if (m_bet > int'(chips)) m_bet = int'(chips);
            end
          endcase
          chk_eq("rnd_step", cur_bet, m_bet);
        end
        confirm_and_check("rnd");
        tick($urandom_range(0, 6));
        chk_eq("rnd_hold_value", bet_value, m_bet);
      end
      handshake("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
